operand_route_stage: RTL

//  Parametrised, registered operand/flag router between the ALU-class register banks and the execute stage.
//  - Picks A, B and ZNC from one of NUM_SRC source banks.
//  - The bank is chosen by the opcode class field op_code[OP_W-1 -: SEL_W], through a writable class->source map.
//  - One output pipeline register plus a one-entry skid buffer, with valid/ready flow control on both sides.

---
 rtl/operand_route_stage.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/operand_route_stage.sv
// Registered operand/flag router: opcode class -> writable source map -> bank mux -> output reg + one-entry skid.
// Optional sticky bad-index flag on route_err when ROUTE_ERR_EN is defined; otherwise route_err is tied 0.
module operand_route_stage #(
    parameter  int DATA_W  = 16,
    parameter  int FLAG_W  = 3,
    parameter  int OP_W    = 16,
    parameter  int SEL_W   = 2,
    parameter  int NUM_SRC = 3,
    localparam int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [OP_W-1:0]           op_code,
    input  logic [NUM_SRC*DATA_W-1:0] src_a,
    input  logic [NUM_SRC*DATA_W-1:0] src_b,
    input  logic [NUM_SRC*FLAG_W-1:0] src_znc,
    input  logic                      map_we,
    input  logic [SEL_W-1:0]          map_addr,
    input  logic [IDX_W-1:0]          map_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_a,
    output logic [DATA_W-1:0]         out_b,
    output logic [FLAG_W-1:0]         out_znc,
    output logic [SEL_W-1:0]          out_class,
    output logic                      route_err
);

    localparam int NUM_CLS = 1 << SEL_W;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [FLAG_W-1:0] znc;
        logic [SEL_W-1:0]  cls;
    } txn_t;

    logic [IDX_W-1:0] r_map [NUM_CLS];
    txn_t             r_out;
    txn_t             r_skid;
    logic             r_out_valid;
    logic             r_skid_valid;
    logic             r_in_ready;

    logic [SEL_W-1:0] w_class;
    logic [IDX_W-1:0] w_idx;
    txn_t             w_new;
    logic             w_accept;
    logic             w_out_free;
    logic             w_skid_next;
    logic             w_unused_op;

    assign w_class     = op_code[OP_W-1 -: SEL_W];
    assign w_idx       = r_map[w_class];
    assign w_accept    = in_valid && r_in_ready;
    assign w_out_free  = !r_out_valid || out_ready;
    assign w_unused_op = ^op_code[OP_W-SEL_W-1:0];

    // Skid holds an entry only when the output could not take one this cycle.
    assign w_skid_next = w_out_free ? (r_skid_valid && w_accept)
                                    : (r_skid_valid || w_accept);

    // Out-of-range indices match no bank and leave the all-zero default.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        w_new     = '0;
        w_new.cls = w_class;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (w_idx == IDX_W'(k)) begin
                w_new.a   = src_a[k*DATA_W +: DATA_W];
                w_new.b   = src_b[k*DATA_W +: DATA_W];
                w_new.znc = src_znc[k*FLAG_W +: FLAG_W];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the map is a small register array with architectural defaults, so it is reset explicitly.
            for (int c = 0; c < NUM_CLS; c++) begin
                if (c == 0)
                    r_map[c] <= '0;
                else if (c == NUM_CLS - 1)
                    r_map[c] <= IDX_W'(2);
                else
                    r_map[c] <= IDX_W'(1);
            end
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_in_ready   <= 1'b0;
        end else begin
            if (map_we)
                r_map[map_addr] <= map_data;

            if (w_out_free) begin
                if (r_skid_valid) begin
                    r_out       <= r_skid;
                    r_out_valid <= 1'b1;
                    if (w_accept)
                        r_skid <= w_new;
                end else begin
                    r_out_valid <= w_accept;
                    if (w_accept)
                        r_out <= w_new;
                end
            end else if (w_accept) begin
                r_skid <= w_new;
            end

            r_skid_valid <= w_skid_next;
            r_in_ready   <= !w_skid_next;
        end
    end

`ifdef ROUTE_ERR_EN
    logic r_route_err;

    always_ff @(posedge clk) begin
        if (reset)
            r_route_err <= 1'b0;
        else if ((w_accept && (32'(w_idx) >= 32'(NUM_SRC))) ||
                 (map_we && (32'(map_data) >= 32'(NUM_SRC))))
            r_route_err <= 1'b1;
    end

    assign route_err = r_route_err;
`else
    assign route_err = 1'b0;
`endif

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_a     = r_out.a;
    assign out_b     = r_out.b;
    assign out_znc   = r_out.znc;
    assign out_class = r_out.cls;

endmodule
